seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Sequential double-dabble BCD converter feeding a 4-digit multiplexed
// common-anode 7-segment scanner, all on one system clock.
module seg_scan_driver #(
  parameter int   SCAN_DIV = 3000,
  parameter logic BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        neg,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_n
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [13:0]      sh_q;
  logic             neg_q, ovf_q;
  logic [15:0]      bcd_q, bcd_adj;
  logic [3:0]       iter_q;
  logic [3:0][7:0]  pat_q, pat_nxt;
  logic [CW-1:0]    div_q;
  logic [1:0]       idx_q, idx_nxt, msd;
  logic             tick, show_neg, err;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (iter_q == 4'd13) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // A 1 carried out of the 16-bit accumulator means a fifth BCD digit,
  // i.e. value >= 10000; the sticky flag stands in for a magnitude compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
      iter_q <= '0;
      pat_q  <= {4{8'hFF}};
    end else begin
      case (state)
        IDLE: if (load) begin
          sh_q   <= value;
          neg_q  <= neg;
          ovf_q  <= 1'b0;
          bcd_q  <= '0;
          iter_q <= '0;
        end
        CONV: begin
          bcd_q  <= {bcd_adj[14:0], sh_q[13]};
          ovf_q  <= ovf_q | bcd_adj[15];
          sh_q   <= {sh_q[12:0], 1'b0};
          iter_q <= iter_q + 4'd1;
        end
        COMMIT:  pat_q <= pat_nxt;
        default: ;
      endcase
    end
  end

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++)
      if (bcd_q[4*i +: 4] != 4'd0) msd = 2'(i);
    err      = ovf_q || (neg_q && (bcd_q[15:12] != 4'd0));
    show_neg = neg_q && (bcd_q != 16'd0);
    for (int i = 0; i < 4; i++) begin
      pat_nxt[i] = seg7(bcd_q[4*i +: 4]);
      if (BLANK_LZ && (2'(i) > msd)) pat_nxt[i] = 8'hFF;
    end
    // Non-error negatives are <= 999, so msd+1 never wraps here.
    if (show_neg) begin
      if (BLANK_LZ) pat_nxt[msd + 2'd1] = 8'hBF;
      else          pat_nxt[3]          = 8'hBF;
    end
    if (err) pat_nxt = {4{8'hBF}};
  end

  assign tick    = (div_q == CW'(SCAN_DIV - 1));
  assign idx_nxt = idx_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= 2'd0;
      dig_n <= 4'b1110;
      seg_n <= 8'hFF;
    end else begin
      div_q <= tick ? '0 : div_q + CW'(1);
      if (tick) begin
        idx_q <= idx_nxt;
        dig_n <= ~(4'b0001 << idx_nxt);
        seg_n <= pat_q[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero blanking on/off)
// compared every cycle against an arithmetic display model, plus literal frames.
module tb_seg_scan_driver;

  localparam int SD = 4;

  logic        clk, rst_n, neg, load;
  logic [13:0] value;
  logic        busy1, busy0;
  logic [7:0]  seg1, seg0;
  logic [3:0]  dig1, dig0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .neg(neg), .load(load),
    .busy(busy1), .seg_n(seg1), .dig_n(dig1));

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .neg(neg), .load(load),
    .busy(busy0), .seg_n(seg0), .dig_n(dig0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Display contents from decimal arithmetic: {digit3,digit2,digit1,digit0}.
  function automatic logic [31:0] exp_pattern(int v, bit n, bit blz);
    logic [31:0] r;
    int nd, d;
    if (v > 9999 || (n && v > 999)) return {4{8'hBF}};
    nd = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    r = '1;
    for (int i = 0; i < 4; i++) begin
      d = (v / (10 ** i)) % 10;
      if (!blz || i < nd) r[8*i +: 8] = segtab[d];
    end
    if (n && v != 0) begin
      if (blz) r[8*nd +: 8] = 8'hBF;
      else     r[31:24]     = 8'hBF;
    end
    return r;
  endfunction

  // Model: edges since reset give the scan slot; a load seen while idle
  // starts a 15-cycle busy window whose last edge publishes the new display.
  int          m_n, m_left, idx;
  logic [13:0] m_v;
  logic        m_ng;
  logic [31:0] m_pat1, m_pat0;
  logic [7:0]  m_seg1, m_seg0;
  logic [3:0]  m_dig;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n <= 0; m_left <= 0;
      m_pat1 <= '1; m_pat0 <= '1;
      m_seg1 <= 8'hFF; m_seg0 <= 8'hFF; m_dig <= 4'b1110;
    end else begin
      if ((m_n + 1) % SD == 0) begin
        idx = ((m_n + 1) / SD) % 4;
        m_dig  <= ~(4'b0001 << idx);
        m_seg1 <= m_pat1[8*idx +: 8];
        m_seg0 <= m_pat0[8*idx +: 8];
      end
      m_n <= m_n + 1;
      if (m_left == 0) begin
        if (load) begin m_left <= 15; m_v <= value; m_ng <= neg; end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_pat1 <= exp_pattern(int'(m_v), m_ng, 1'b1);
          m_pat0 <= exp_pattern(int'(m_v), m_ng, 1'b0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy1", 32'(busy1), 32'(m_left != 0));
      chk("busy0", 32'(busy0), 32'(m_left != 0));
      chk("dig1", 32'(dig1), 32'(m_dig));
      chk("dig0", 32'(dig0), 32'(m_dig));
      chk("seg1", 32'(seg1), 32'(m_seg1));
      chk("seg0", 32'(seg0), 32'(m_seg0));
    end
  end

  // Called at posedge+1; the next edge samples the load.
  task automatic do_load(input int v, input bit n);
    value = 14'(v); neg = n; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy1) break;
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && busy1; k++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", 32'(busy1), 32'd0);
  endtask

  task automatic capture(output logic [31:0] f1, output logic [31:0] f0);
    repeat (4 * SD + 2) @(posedge clk);
    f1 = 'x; f0 = 'x;
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (dig1 == ~(4'b0001 << i)) f1[8*i +: 8] = seg1;
        if (dig0 == ~(4'b0001 << i)) f0[8*i +: 8] = seg0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic load_and_show(input int v, input bit n,
                               output logic [31:0] f1, output logic [31:0] f0);
    do_load(v, n);
    wait_idle();
    capture(f1, f0);
  endtask

  logic [3:0]  steps [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [31:0] f1, f0;
  int          c;

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; neg = 1'b0;

    chk("model_1234", exp_pattern(1234, 1'b0, 1'b1), 32'hF9A4B099);
    chk("model_42n",  exp_pattern(42, 1'b1, 1'b1),   32'hFFBF99A4);
    chk("model_5lz0", exp_pattern(5, 1'b0, 1'b0),    32'hC0C0C092);
    chk("model_1000n", exp_pattern(1000, 1'b1, 1'b1), 32'hBFBFBFBF);

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_dig",  32'(dig1),  32'h0000000E);
    chk("rst_seg",  32'(seg1),  32'h000000FF);
    chk_en = 1;
    rst_n  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (SD) @(posedge clk); #1;
      chk("scan_step", 32'(dig1), 32'(steps[k]));
    end

    do_load(1234, 1'b0);
    count_busy(c);
    chk("busy_len", c, 15);
    capture(f1, f0);
    chk("frame_1234", f1, 32'hF9A4B099);

    load_and_show(7, 1'b0, f1, f0);
    chk("frame_7", f1, 32'hFFFFFFF8);
    load_and_show(42, 1'b1, f1, f0);
    chk("frame_m42", f1, 32'hFFBF99A4);
    load_and_show(10000, 1'b0, f1, f0);
    chk("frame_10000", f1, 32'hBFBFBFBF);
    load_and_show(1000, 1'b1, f1, f0);
    chk("frame_m1000", f1, 32'hBFBFBFBF);
    load_and_show(0, 1'b1, f1, f0);
    chk("frame_m0", f1, 32'hFFFFFFC0);
    chk("frame_m0_lz0", f0, 32'hC0C0C0C0);

    // 9999 with a load pulse mid-conversion and one on the release edge
    do_load(9999, 1'b0);
    repeat (2) @(posedge clk); #1;
    do_load(5, 1'b0);
    repeat (11) @(posedge clk); #1;
    do_load(5, 1'b0);
    chk("busy_at_L16", 32'(busy1), 32'd0);
    capture(f1, f0);
    chk("frame_9999", f1, 32'h90909090);
    chk("frame_9999_lz0", f0, 32'h90909090);

    load_and_show(5, 1'b0, f1, f0);
    chk("frame_5_lz0", f0, 32'hC0C0C092);
    chk("frame_5", f1, 32'hFFFFFF92);

    do_load(1234, 1'b0);
    repeat (6) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_seg",  32'(seg1),  32'h000000FF);
    chk("midrst_dig",  32'(dig1),  32'h0000000E);
    rst_n = 1'b1;
    capture(f1, f0);
    chk("midrst_blank", f1, 32'hFFFFFFFF);
    load_and_show(56, 1'b0, f1, f0);
    chk("frame_56", f1, 32'hFFFF9282);
    chk("frame_56_lz0", f0, 32'hC0C09282);

    for (int k = 0; k < 1500; k++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 999))
                                          : 14'($urandom_range(0, 16383));
      neg   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    load = 1'b0;
    repeat (4 * SD + 20) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
